// File: rtl/mip_vram_pkg.sv
// Shared constants, sample type and engine states for the MIP/MinIP frame buffer.
package mip_vram_pkg;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int WORDS = H_RES * V_RES / 4;
  localparam int AW    = $clog2(WORDS);

  localparam logic [31:0] FILL_MIP   = 32'h0000_0000;
  localparam logic [31:0] FILL_MINIP = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] density;
  } calc_res_t;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_READ, S_WRITE} state_t;

  function automatic logic [31:0] fill_word(input logic minip);
    return minip ? FILL_MINIP : FILL_MIP;
  endfunction
endpackage

// File: rtl/vram_dp_bram.sv
// True dual-port 32-bit RAM, read-first, registered outputs; port A wins a same-word write collision.
module vram_dp_bram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_a_en,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [31:0]   i_a_din,
  output logic [31:0]   o_a_dout,
  input  logic          i_b_en,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [31:0]   i_b_din,
  output logic [31:0]   o_b_dout
);
  logic [31:0] r_mem [DEPTH];

  // Port A write is issued last so it overrides port B on the same word.
  always_ff @(posedge i_clk) begin
    if (i_b_en && i_b_we) r_mem[i_b_addr] <= i_b_din;
    if (i_a_en && i_a_we) r_mem[i_a_addr] <= i_a_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_a_dout <= '0;
      o_b_dout <= '0;
    end else begin
      if (i_a_en && !i_a_we) o_a_dout <= r_mem[i_a_addr];
      if (i_b_en && !i_b_we) o_b_dout <= r_mem[i_b_addr];
    end
  end
endmodule

// File: rtl/mip_vram.sv
// Four-lane round-robin read-modify-write engine accumulating a MIP/MinIP image into a dual-port RAM.
module mip_vram import mip_vram_pkg::*; #(
  parameter int P_H_RES = H_RES,
  parameter int P_V_RES = V_RES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_calc_res_0_data_valid,
  output logic        io_calc_res_0_rden,
  input  logic [9:0]  io_calc_res_0_screen_pos_x,
  input  logic [9:0]  io_calc_res_0_screen_pos_y,
  input  logic [7:0]  io_calc_res_0_density,
  input  logic        io_calc_res_1_data_valid,
  output logic        io_calc_res_1_rden,
  input  logic [9:0]  io_calc_res_1_screen_pos_x,
  input  logic [9:0]  io_calc_res_1_screen_pos_y,
  input  logic [7:0]  io_calc_res_1_density,
  input  logic        io_calc_res_2_data_valid,
  output logic        io_calc_res_2_rden,
  input  logic [9:0]  io_calc_res_2_screen_pos_x,
  input  logic [9:0]  io_calc_res_2_screen_pos_y,
  input  logic [7:0]  io_calc_res_2_density,
  input  logic        io_calc_res_3_data_valid,
  output logic        io_calc_res_3_rden,
  input  logic [9:0]  io_calc_res_3_screen_pos_x,
  input  logic [9:0]  io_calc_res_3_screen_pos_y,
  input  logic [7:0]  io_calc_res_3_density,
  input  logic        io_en_minip,
  input  logic [31:0] io_ram_port_addra,
  input  logic [31:0] io_ram_port_dina,
  output logic [31:0] io_ram_port_douta,
  input  logic        io_ram_port_ena,
  input  logic        io_ram_port_wea,
  input  logic        io_ram_reset,
  output logic        io_ram_reset_busy
);
  localparam int               L_WORDS = P_H_RES * P_V_RES / 4;
  localparam int               L_AW    = $clog2(L_WORDS);
  localparam int               L_IW    = L_AW + 2;
  localparam logic [L_AW-1:0]  L_LAST  = L_AW'(L_WORDS - 1);
  localparam logic [9:0]       L_HMAX  = 10'(P_H_RES);
  localparam logic [9:0]       L_VMAX  = 10'(P_V_RES);

  state_t            r_state, w_nstate;
  logic [L_AW-1:0]   r_clr_addr, r_word, w_word, w_b_addr;
  logic [1:0]        r_ptr, r_byte, w_sel;
  logic [7:0]        r_dens, w_old, w_new;
  logic [3:0]        w_valid, w_rden;
  logic              w_any, w_inr, w_pop, w_b_en, w_b_we;
  logic [31:0]       w_b_din, w_b_dout, w_merged;
  logic [L_IW-1:0]   w_idx;
  calc_res_t         w_lane [4];
  calc_res_t         w_smp;
  logic              w_unused_addr;

  assign w_lane[0] = {io_calc_res_0_screen_pos_x, io_calc_res_0_screen_pos_y, io_calc_res_0_density};
  assign w_lane[1] = {io_calc_res_1_screen_pos_x, io_calc_res_1_screen_pos_y, io_calc_res_1_density};
  assign w_lane[2] = {io_calc_res_2_screen_pos_x, io_calc_res_2_screen_pos_y, io_calc_res_2_density};
  assign w_lane[3] = {io_calc_res_3_screen_pos_x, io_calc_res_3_screen_pos_y, io_calc_res_3_density};
  assign w_valid   = {io_calc_res_3_data_valid, io_calc_res_2_data_valid,
                      io_calc_res_1_data_valid, io_calc_res_0_data_valid};
  assign w_unused_addr = ^io_ram_port_addra[31:L_AW];

  // Descending scan so the lane closest to the pointer is the last (winning) assignment.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    for (int k = 3; k >= 0; k--)
      if (w_valid[2'(r_ptr + 2'(k))]) begin
        w_any = 1'b1;
        w_sel = 2'(r_ptr + 2'(k));
      end
  end

  assign w_smp  = w_lane[w_sel];
  assign w_inr  = (w_smp.x < L_HMAX) && (w_smp.y < L_VMAX);
  assign w_idx  = L_IW'(w_smp.y) * L_IW'(P_H_RES) + L_IW'(w_smp.x);
  assign w_word = w_idx[L_IW-1:2];
  assign w_pop  = (r_state == S_IDLE) && !io_ram_reset && w_any;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_ptr      <= '0;
      r_word     <= '0;
      r_byte     <= '0;
      r_dens     <= '0;
    end else begin
      r_state <= w_nstate;
      if (io_ram_reset)            r_clr_addr <= '0;
      else if (r_state == S_CLEAR) r_clr_addr <= r_clr_addr + 1'b1;
      if (w_pop) begin
        r_ptr  <= w_sel + 2'd1;
        r_word <= w_word;
        r_byte <= w_idx[1:0];
        r_dens <= w_smp.density;
      end
    end
  end

  // Out-of-range samples are popped but stay in IDLE, so they never touch the RAM.
  always_comb begin
    w_nstate = r_state;
    if (io_ram_reset) w_nstate = S_CLEAR;
    else case (r_state)
      S_CLEAR: if (r_clr_addr == L_LAST) w_nstate = S_IDLE;
      S_IDLE:  if (w_any && w_inr) w_nstate = S_READ;
      S_READ:  w_nstate = S_WRITE;
      S_WRITE: w_nstate = S_IDLE;
      default: w_nstate = S_CLEAR;
    endcase
  end

  always_comb begin
    w_old    = w_b_dout[{r_byte, 3'b000} +: 8];
    w_new    = io_en_minip ? ((w_old < r_dens) ? w_old : r_dens)
                           : ((w_old > r_dens) ? w_old : r_dens);
    w_merged = w_b_dout;
    w_merged[{r_byte, 3'b000} +: 8] = w_new;
  end

  always_comb begin
    w_rden            = '0;
    w_b_en            = 1'b0;
    w_b_we            = 1'b0;
    w_b_addr          = r_word;
    w_b_din           = '0;
    io_ram_reset_busy = (r_state == S_CLEAR);
    case (r_state)
      S_CLEAR: begin
        w_b_en   = 1'b1;
        w_b_we   = 1'b1;
        w_b_addr = r_clr_addr;
        w_b_din  = fill_word(io_en_minip);
      end
      S_IDLE:  if (w_pop) w_rden[w_sel] = 1'b1;
      S_READ:  w_b_en = 1'b1;
      S_WRITE: if (!io_ram_reset) begin
        w_b_en  = 1'b1;
        w_b_we  = 1'b1;
        w_b_din = w_merged;
      end
      default: ;
    endcase
  end

  assign {io_calc_res_3_rden, io_calc_res_2_rden, io_calc_res_1_rden, io_calc_res_0_rden} = w_rden;

  vram_dp_bram #(.DEPTH(L_WORDS), .AW(L_AW)) u_ram (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_a_en   (io_ram_port_ena),
    .i_a_we   (io_ram_port_wea),
    .i_a_addr (io_ram_port_addra[L_AW-1:0]),
    .i_a_din  (io_ram_port_dina),
    .o_a_dout (io_ram_port_douta),
    .i_b_en   (w_b_en),
    .i_b_we   (w_b_we),
    .i_b_addr (w_b_addr),
    .i_b_din  (w_b_din),
    .o_b_dout (w_b_dout)
  );
endmodule

// File: tb/tb_mip_vram.sv
// Scoreboard bench for mip_vram: stimulus queues expected rden lanes and read data, a negedge monitor checks them.
module tb_mip_vram;
  import mip_vram_pkg::*;
  localparam int HR = 640, VR = 16, NW = HR * VR / 4;

  logic        clk = 0, rst = 1;
  logic [3:0]  vld, rden;
  logic [9:0]  px [4];
  logic [9:0]  py [4];
  logic [7:0]  pd [4];
  logic        minip = 0, ena = 0, wea = 0, ram_rst = 0, busy;
  logic [31:0] addra = 0, dina = 0, douta;

  calc_res_t lmem [4][16];
  int        lwr [4];
  int        lrd [4];
  int        exp_lane [$];
  logic [31:0] exp_rd [$];
  int        n_chk = 0, n_pass = 0, cyc = 0, last_rden = 0, rr_cnt = 0;
  logic      rd_pipe = 0, rr_phase = 0, rden_busy_seen = 0;

  always #5 clk = ~clk;

  always_comb
    for (int n = 0; n < 4; n++) begin
      vld[n] = (lrd[n] != lwr[n]);
      px[n]  = lmem[n][lrd[n] % 16].x;
      py[n]  = lmem[n][lrd[n] % 16].y;
      pd[n]  = lmem[n][lrd[n] % 16].density;
    end

  mip_vram #(.P_H_RES(HR), .P_V_RES(VR)) dut (
    .clock(clk), .reset(rst),
    .io_calc_res_0_data_valid(vld[0]), .io_calc_res_0_rden(rden[0]),
    .io_calc_res_0_screen_pos_x(px[0]), .io_calc_res_0_screen_pos_y(py[0]), .io_calc_res_0_density(pd[0]),
    .io_calc_res_1_data_valid(vld[1]), .io_calc_res_1_rden(rden[1]),
    .io_calc_res_1_screen_pos_x(px[1]), .io_calc_res_1_screen_pos_y(py[1]), .io_calc_res_1_density(pd[1]),
    .io_calc_res_2_data_valid(vld[2]), .io_calc_res_2_rden(rden[2]),
    .io_calc_res_2_screen_pos_x(px[2]), .io_calc_res_2_screen_pos_y(py[2]), .io_calc_res_2_density(pd[2]),
    .io_calc_res_3_data_valid(vld[3]), .io_calc_res_3_rden(rden[3]),
    .io_calc_res_3_screen_pos_x(px[3]), .io_calc_res_3_screen_pos_y(py[3]), .io_calc_res_3_density(pd[3]),
    .io_en_minip(minip),
    .io_ram_port_addra(addra), .io_ram_port_dina(dina), .io_ram_port_douta(douta),
    .io_ram_port_ena(ena), .io_ram_port_wea(wea),
    .io_ram_reset(ram_rst), .io_ram_reset_busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // FWFT lane model: pop on the clock edge where rden is seen.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_pipe <= ena && !wea;
    for (int n = 0; n < 4; n++) if (rden[n]) lrd[n] <= lrd[n] + 1;
  end

  always @(negedge clk) if (!rst) begin
    if (busy && |rden) rden_busy_seen = 1;
    if (|rden) begin
      logic [3:0] e;
      e = '0;
      if (exp_lane.size() > 0) e = 4'(1 << exp_lane.pop_front());
      chk("rden_lane", 32'(rden), 32'(e));
      chk("rden_without_valid", 32'(rden & ~vld), 32'd0);
      if (rr_phase) begin
        if (rr_cnt > 0) chk("rr_gap", 32'(cyc - last_rden), 32'd3);
        rr_cnt = rr_cnt + 1;
      end
      last_rden = cyc;
    end
    if (rd_pipe) begin
      logic [31:0] d;
      d = 32'hBAD0_BAD0;
      if (exp_rd.size() > 0) d = exp_rd.pop_front();
      chk("douta", douta, d);
    end
  end

  task automatic push(input int l, input int x, input int y, input logic [7:0] d);
    lmem[l][lwr[l] % 16] = '{x: 10'(x), y: 10'(y), density: d};
    lwr[l] = lwr[l] + 1;
    exp_lane.push_back(l);
  endtask

  task automatic rd(input int a, input logic [31:0] e);
    ena = 1; wea = 0; addra = 32'(a);
    exp_rd.push_back(e);
    @(posedge clk); #1 ena = 0;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    ena = 1; wea = 1; addra = 32'(a); dina = d;
    @(posedge clk); #1 ena = 0; wea = 0;
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 2 * NW + 10) begin n++; @(negedge clk); end
    chk(nm, 32'(n), 32'(NW));
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while ((lrd[0] != lwr[0] || lrd[1] != lwr[1] || lrd[2] != lwr[2] || lrd[3] != lwr[3]) && n < 200) begin
      n++; @(posedge clk);
    end
    chk(nm, 32'(n < 200), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ram_reset();
    ram_rst = 1; @(posedge clk); #1 ram_rst = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_douta", douta, 32'd0);
    chk("reset_rden", 32'(rden), 32'd0);
    @(posedge clk); #1 rst = 0;
    wait_clear("reset_clear_len");
    rd(0, 32'h0);
    rd(NW - 1, 32'h0);

    // round-robin, pointer starts at 0 after reset
    rr_phase = 1;
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < 4; l++) push(l, l, 0, 8'(8'h11 * (l + 1)));
    wait_drain("rr_drain");
    rr_phase = 0;
    rd(0, 32'h4433_2211);

    // MIP accumulate at x=5 -> word 1 byte 1
    push(0, 5, 0, 8'h40);
    push(0, 5, 0, 8'h20);
    wait_drain("mip_drain1");
    rd(1, 32'h0000_4000);
    push(0, 5, 0, 8'h80);
    wait_drain("mip_drain2");
    rd(1, 32'h0000_8000);

    wr(100, 32'hDEAD_BEEF);
    rd(100, 32'hDEAD_BEEF);

    // out-of-range, aliased index 10*640+700 = 7100 -> word 1775
    push(0, 700, 10, 8'hFF);
    wait_drain("oor_drain");
    rd(1775, 32'h0);
    rd(0, 32'h4433_2211);
    rd(1, 32'h0000_8000);

    // MinIP
    minip = 1;
    pulse_ram_reset();
    wait_clear("minip_clear_len");
    rd(0, 32'hFFFF_FFFF);
    rd(NW - 1, 32'hFFFF_FFFF);
    push(0, 0, 0, 8'h30);
    push(0, 0, 0, 8'h50);
    wait_drain("minip_drain");
    rd(0, 32'hFFFF_FF30);

    // clear during READ: lane1 sample must be abandoned
    push(1, 1, 0, 8'h10);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!rden[1] && n < 50) begin n++; @(negedge clk); end
      chk("mid_rden_seen", 32'(n < 50), 32'd1);
    end
    @(posedge clk); #1 ram_rst = 1;
    rden_busy_seen = 0;
    push(2, 2, 0, 8'h40);
    @(posedge clk); #1 ram_rst = 0;
    wait_clear("mid_clear_len");
    chk("rden_while_busy", 32'(rden_busy_seen), 32'd0);
    wait_drain("mid_drain");
    rd(0, 32'hFF40_FFFF);

    repeat (3) @(posedge clk);
    chk("rden_sb_empty", 32'(exp_lane.size()), 32'd0);
    chk("rd_sb_empty", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
